// File: rtl/reg_writeback.sv
// Write-back stage: queues ALU and load results in order and retires one
// register-file write per cycle, exposing pending/forwarding info to decode.
module reg_writeback #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_addr,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_addr,
    input  logic [DATA_W-1:0]          mem_data,
    input  logic                       wb_hold,
    output logic                       rf_en,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic [2**ADDR_W-1:0]       pending,
    input  logic [ADDR_W-1:0]          fwd_addr,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_q_addr [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_rf_en;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_push_addr;
    logic [DATA_W-1:0] w_push_data;
    logic [DEPTH-1:0]  w_valid;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign alu_ready = !w_full;
    assign mem_ready = !w_full && !alu_valid;

    // ALU wins any contention, so at most one result enters per cycle.
    assign w_push      = (alu_valid && alu_ready) || (mem_valid && mem_ready);
    assign w_push_addr = alu_valid ? alu_addr : mem_addr;
    assign w_push_data = alu_valid ? alu_data : mem_data;
    assign w_pop       = (r_count != '0) && !wb_hold;

    // Slot gi holds a live entry when its distance from head is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            assign w_valid[gi] = ({1'b0, PTR_W'(gi) - r_head} < r_count);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_tail] <= w_push_addr;
            r_q_data[r_tail] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_rf_en    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head     <= r_head + 1'b1;
                r_rf_en    <= 1'b1;
                r_rf_waddr <= r_q_addr[r_head];
                r_rf_wdata <= r_q_data[r_head];
            end else begin
                r_rf_en    <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rf_en    = r_rf_en;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign count    = r_count;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) begin
                pending[r_q_addr[i]] = 1'b1;
            end
        end
        if (r_rf_en) begin
            pending[r_rf_waddr] = 1'b1;
        end
    end

    // Scan oldest to newest after the rf stage so the newest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (r_rf_en && (r_rf_waddr == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = r_rf_wdata;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) && (r_q_addr[r_head + PTR_W'(k)] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_q_data[r_head + PTR_W'(k)];
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: hand-computed vectors covering ordering,
// contention, backpressure, forwarding, reset and streaming push/pop.
module tb_reg_writeback;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              wb_hold;
    logic              rf_en;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [2:0]        count;
    logic [15:0]       pending;
    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_hold(wb_hold), .rf_en(rf_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .count(count), .pending(pending),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_offer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_valid = 1'b1;
        alu_addr  = a;
        alu_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] exp_a [$];
        logic [DATA_W-1:0] exp_d [$];

        rst_n = 1'b0; alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0; wb_hold = 1'b0; fwd_addr = '0;
        #2;
        check("rst_rf_en",    32'(rf_en),    32'd0);
        check("rst_waddr",    32'(rf_waddr), 32'd0);
        check("rst_wdata",    32'(rf_wdata), 32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_pending",  32'(pending),  32'd0);
        check("rst_fwd_hit",  32'(fwd_hit),  32'd0);
        check("rst_fwd_data", 32'(fwd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single write
        alu_offer(4'd3, 8'h5A); fwd_addr = 4'd3;
        #1 check("t1_alu_ready", 32'(alu_ready), 32'd1);
        tick; alu_valid = 1'b0;
        check("t1_count_e1",   32'(count),      32'd1);
        check("t1_pend_e1",    32'(pending[3]), 32'd1);
        check("t1_rf_en_e1",   32'(rf_en),      32'd0);
        tick;
        check("t1_rf_en_e2",   32'(rf_en),      32'd1);
        check("t1_waddr_e2",   32'(rf_waddr),   32'd3);
        check("t1_wdata_e2",   32'(rf_wdata),   32'h5A);
        check("t1_count_e2",   32'(count),      32'd0);
        check("t1_pend_e2",    32'(pending[3]), 32'd1);
        check("t1_fwd_hit_e2", 32'(fwd_hit),    32'd1);
        check("t1_fwd_dat_e2", 32'(fwd_data),   32'h5A);
        tick;
        check("t1_rf_en_e3",   32'(rf_en),      32'd0);
        check("t1_pend_e3",    32'(pending),    32'd0);
        check("t1_fwd_hit_e3", 32'(fwd_hit),    32'd0);

        // 2: contention, ALU first
        alu_offer(4'd1, 8'h11);
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 8'h22;
        #1;
        check("t2_alu_ready", 32'(alu_ready), 32'd1);
        check("t2_mem_ready", 32'(mem_ready), 32'd0);
        tick; alu_valid = 1'b0;
        #1 check("t2_mem_ready2", 32'(mem_ready), 32'd1);
        tick; mem_valid = 1'b0;
        check("t2_rf_a",  32'({rf_en, rf_waddr, rf_wdata}), {19'd0, 1'b1, 4'd1, 8'h11});
        tick;
        check("t2_rf_b",  32'({rf_en, rf_waddr, rf_wdata}), {19'd0, 1'b1, 4'd2, 8'h22});
        tick;
        check("t2_idle",  32'(rf_en), 32'd0);
        check("t2_count", 32'(count), 32'd0);

        // 3: fill under hold, then release
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_offer(4'(4 + i), 8'(8'h40 + 8'(i * 16)));
            tick;
        end
        alu_offer(4'd8, 8'h80);
        #1;
        check("t3_count_full", 32'(count),     32'd4);
        check("t3_alu_ready",  32'(alu_ready), 32'd0);
        check("t3_mem_ready",  32'(mem_ready), 32'd0);
        check("t3_pending",    32'(pending),   32'h00F0);
        tick;
        check("t3_count_held", 32'(count),     32'd4);
        check("t3_rf_en_held", 32'(rf_en),     32'd0);
        wb_hold = 1'b0;
        tick;
        check("t3_count_d1",   32'(count),     32'd3);
        check("t3_ready_d1",   32'(alu_ready), 32'd1);
        check("t3_rf_d1", 32'({rf_en, rf_waddr, rf_wdata}), {19'd0, 1'b1, 4'd4, 8'h40});
        tick; alu_valid = 1'b0;
        check("t3_count_d2",   32'(count),     32'd3);
        check("t3_rf_d2", 32'({rf_en, rf_waddr, rf_wdata}), {19'd0, 1'b1, 4'd5, 8'h50});
        for (int i = 2; i < 5; i++) begin
            tick;
            check("t3_rf_dn", 32'({rf_en, rf_waddr, rf_wdata}),
                  {19'd0, 1'b1, 4'(4 + i), 8'(8'h40 + 8'(i * 16))});
        end
        tick;
        check("t3_idle",  32'(rf_en), 32'd0);
        check("t3_count", 32'(count), 32'd0);

        // 4: forwarding picks the newest of two writes to r5
        wb_hold = 1'b1;
        alu_offer(4'd5, 8'h01); tick;
        alu_offer(4'd5, 8'h02); tick;
        alu_valid = 1'b0; fwd_addr = 4'd5;
        #1;
        check("t4_hit5",  32'(fwd_hit),    32'd1);
        check("t4_data5", 32'(fwd_data),   32'h02);
        check("t4_pend5", 32'(pending[5]), 32'd1);
        check("t4_pend6", 32'(pending[6]), 32'd0);
        fwd_addr = 4'd6;
        #1;
        check("t4_hit6",  32'(fwd_hit),    32'd0);
        check("t4_data6", 32'(fwd_data),   32'h00);
        fwd_addr = 4'd5; wb_hold = 1'b0;
        tick;
        check("t4_rf_a",   32'({rf_en, rf_waddr, rf_wdata}), {19'd0, 1'b1, 4'd5, 8'h01});
        check("t4_fwd_q",  32'(fwd_data), 32'h02);
        tick;
        check("t4_rf_b",   32'({rf_en, rf_waddr, rf_wdata}), {19'd0, 1'b1, 4'd5, 8'h02});
        check("t4_fwd_rf", 32'({fwd_hit, fwd_data}), {23'd0, 1'b1, 8'h02});
        tick;
        check("t4_idle",   32'({rf_en, fwd_hit}), 32'd0);
        check("t4_pend",   32'(pending), 32'd0);

        // 5: asynchronous reset with queue and rf stage busy
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_offer(4'(9 + i), 8'(8'h90 + 8'(i)));
            tick;
        end
        alu_valid = 1'b0; wb_hold = 1'b0;
        tick;
        check("t5_pre_rf_en", 32'(rf_en), 32'd1);
        check("t5_pre_count", 32'(count), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rf_en",  32'(rf_en),   32'd0);
        check("t5_count",  32'(count),   32'd0);
        check("t5_pend",   32'(pending), 32'd0);
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t5_post_rf_en", 32'(rf_en), 32'd0);
        end

        // 6: streaming push/pop at count=2
        wb_hold = 1'b1;
        alu_offer(4'd13, 8'hD1); exp_a.push_back(4'd13); exp_d.push_back(8'hD1); tick;
        alu_offer(4'd14, 8'hE2); exp_a.push_back(4'd14); exp_d.push_back(8'hE2); tick;
        wb_hold = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                alu_offer(4'(15 - i), 8'(8'hA0 + 8'(i)));
                exp_a.push_back(4'(15 - i));
                exp_d.push_back(8'(8'hA0 + 8'(i)));
            end else begin
                alu_valid = 1'b0;
            end
            tick;
            check("t6_count", 32'(count), (i < 5) ? 32'd2 : 32'(6 - i));
            check("t6_rf", 32'({rf_en, rf_waddr, rf_wdata}),
                  {19'd0, 1'b1, exp_a.pop_front(), exp_d.pop_front()});
        end
        tick;
        check("t6_idle", 32'(rf_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-back unit that owns the register file write port: drives its enable, write address and write data.
- Accepts results from two producers, the ALU and the load unit, over valid/ready handshakes.
- Buffers results in an in-order queue and retires one register write per cycle.
- Exports a per-register pending mask and a forwarding lookup so decode can detect and bypass RAW hazards on not-yet-written registers.

Parameters:
DATA_W, 8, register data width
ADDR_W, 4, register address width
DEPTH, 4, queue entries (power of two, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this edge when high with alu_valid
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load result offered
mem_ready  output  1  load result accepted this edge when high with mem_valid
mem_addr  input  ADDR_W  load destination register
mem_data  input  DATA_W  load result
wb_hold  input  1  when high, no entry drains (debug freeze)
rf_en  output  1  register file write enable (registered)
rf_waddr  output  ADDR_W  register file write address (registered)
rf_wdata  output  DATA_W  register file write data (registered)
count  output  $clog2(DEPTH)+1  queue occupancy
pending  output  2**ADDR_W  bit r high if a write to register r is queued or presented on rf_*
fwd_addr  input  ADDR_W  forwarding lookup address
fwd_hit  output  1  newest outstanding write to fwd_addr exists
fwd_data  output  DATA_W  data of that newest write; 0 when no hit

Behaviour:
- Reset (async assert, sync release): queue emptied, count=0, rf_en=0, rf_waddr=0, rf_wdata=0, pending=0, fwd_hit=0, fwd_data=0. Queued writes are discarded and never appear on rf_*.
- Full means count==DEPTH.
- alu_ready = !full.
- mem_ready = !full && !alu_valid. ALU has fixed priority; at most one enqueue per cycle.
- Readiness ignores a same-cycle dequeue: no write-through into a full queue.
- Enqueue happens on the edge where valid&&ready; the entry is stored at the tail.
- Drain: on each edge where count>0 and !wb_hold, the head entry pops and is loaded into rf_en=1 / rf_waddr / rf_wdata. Otherwise rf_en=0 on that edge; rf_waddr and rf_wdata hold their previous values.
- No bypass from input to rf_*. An entry enqueued at edge N presents on rf_* no earlier than after edge N+1. The register file captures it at edge N+2.
- Simultaneous enqueue and dequeue: count unchanged; FIFO order preserved.
- Pointers wrap modulo DEPTH.
- count is 0..DEPTH. It never exceeds DEPTH and never underflows.
- Order: writes retire in exact acceptance order, including repeated writes to the same register.
- pending is combinational over the valid queue entries plus the rf_* stage (when rf_en=1). A bit clears the cycle after the last covering write has been presented on rf_*.
- Forwarding is combinational. Search order is newest queue entry first, then older entries, then the rf_* stage (when rf_en=1). The first match sets fwd_hit=1 and fwd_data to that entry's data.
- All addresses 0..2**ADDR_W-1 are writable; no register is special-cased.
- wb_hold asserted mid-drain:
  - The currently presented rf_* write still completes.
  - rf_en deasserts on the next edge.
  - The queue keeps accepting entries until full.

Test Plan:
1. Single write: alu r3=0x5A at edge 1, wb_hold=0 -> after edge 2 rf_en=1, rf_waddr=3, rf_wdata=0x5A for one cycle; pending[3]=1 from after edge 1 until after edge 3; count 1 then 0.
2. Contention: alu r1=0x11 and mem r2=0x22 both valid at edge 1 -> alu_ready=1, mem_ready=0; mem accepted at edge 2; rf_* shows r1/0x11 then r2/0x22 on consecutive cycles.
3. Full/backpressure: wb_hold=1, enqueue 4 entries r4..r7 -> count=4, alu_ready=0 and mem_ready=0, 5th offer held. Release hold -> 4 writes r4..r7 on consecutive cycles; alu_ready=1 again after the first drain edge.
4. Forwarding: wb_hold=1, enqueue r5=0x01 then r5=0x02 -> fwd_addr=5 gives hit=1, data=0x02; fwd_addr=6 gives hit=0, data=0x00; pending[5]=1, pending[6]=0.
5. Reset mid-operation: 3 entries queued and rf_en=1, then rst_n=0 between edges -> immediately rf_en=0, count=0, pending=0. After release, no rf_en pulse without new input.
6. Simultaneous push/pop: count=2, alu_valid=1, wb_hold=0 -> count stays 2 across 5 cycles of continuous input; output sequence matches input order with no gaps or duplicates.
